// File: rtl/simon_pkg.sv
// Shared definitions for the SIMON key-schedule engine: z sequences,
// round/sequence lookup per (N,M) and the controller state encoding.
package simon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRECOMP = 2'd1,
    EMIT    = 2'd2
  } state_e;

  // Sequences written as they appear in the literature: element 0 is the
  // leftmost (most significant) character of each literal.
  localparam logic [61:0] Z0_SEQ = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1_SEQ = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2_SEQ = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3_SEQ = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4_SEQ = 62'b11010001111001101011011000100000010111000011001010010011101111;

  // Reorders a literal so that bit t holds element t of the sequence.
  function automatic logic [61:0] seq_to_table(input logic [61:0] s);
    logic [61:0] r;
    for (int t = 0; t < 62; t++) begin
      r[t] = s[61-t];
    end
    return r;
  endfunction

  localparam logic [4:0][61:0] Z_TABLE = {
    seq_to_table(Z4_SEQ),
    seq_to_table(Z3_SEQ),
    seq_to_table(Z2_SEQ),
    seq_to_table(Z1_SEQ),
    seq_to_table(Z0_SEQ)
  };

  // Number of rounds for a (word size, key words) pair; 0 marks an illegal pair.
  function automatic int simon_rounds(input int n, input int m);
    int t;
    t = 0;
    case ({n[7:0], m[7:0]})
      {8'd16, 8'd4}: t = 32;
      {8'd24, 8'd3}: t = 36;
      {8'd24, 8'd4}: t = 36;
      {8'd32, 8'd3}: t = 42;
      {8'd32, 8'd4}: t = 44;
      {8'd48, 8'd2}: t = 52;
      {8'd48, 8'd3}: t = 54;
      {8'd64, 8'd2}: t = 68;
      {8'd64, 8'd3}: t = 69;
      {8'd64, 8'd4}: t = 72;
      default:       t = 0;
    endcase
    return t;
  endfunction

  // Which z sequence a (word size, key words) pair uses.
  function automatic int simon_zsel(input int n, input int m);
    int j;
    j = 0;
    case ({n[7:0], m[7:0]})
      {8'd16, 8'd4}: j = 0;
      {8'd24, 8'd3}: j = 0;
      {8'd24, 8'd4}: j = 1;
      {8'd32, 8'd3}: j = 2;
      {8'd32, 8'd4}: j = 3;
      {8'd48, 8'd2}: j = 2;
      {8'd48, 8'd3}: j = 3;
      {8'd64, 8'd2}: j = 2;
      {8'd64, 8'd3}: j = 3;
      {8'd64, 8'd4}: j = 4;
      default:       j = 0;
    endcase
    return j;
  endfunction

  function automatic bit simon_legal(input int n, input int m);
    return simon_rounds(n, m) != 0;
  endfunction

endpackage

// File: rtl/simon_key_step.sv
// One SIMON key-schedule step. Forward: window k[i..i+M-1] -> k[i+M].
// Inverse: window k[i..i+M-1] -> k[i-1]. Both directions share the same
// rotate/xor core; only the operand selection differs.
module simon_key_step #(
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic [M-1:0][N-1:0] win_i,
  input  logic                z_i,
  input  logic                inv_i,
  output logic [N-1:0]        word_o
);

  localparam logic [N-1:0] RC = {{(N-2){1'b1}}, 2'b00};

  logic [N-1:0] rot_src;
  logic [N-1:0] xor_src;
  logic [N-1:0] base;
  logic [N-1:0] x_term;
  logic [N-1:0] tmp_a;
  logic [N-1:0] tmp_b;

  // Operand selection by direction, then the shared rotate/xor core.
  always_comb begin
    rot_src = inv_i ? win_i[M-2] : win_i[M-1];
    xor_src = inv_i ? win_i[0]   : win_i[1];
    base    = inv_i ? win_i[M-1] : win_i[0];
    x_term  = (M == 4) ? xor_src : '0;
    tmp_a   = {rot_src[2:0], rot_src[N-1:3]} ^ x_term;
    tmp_b   = tmp_a ^ {tmp_a[0], tmp_a[N-1:1]};
    word_o  = RC ^ {{(N-1){1'b0}}, z_i} ^ base ^ tmp_b;
  end

endmodule

// File: rtl/simon_key_sched.sv
// SIMON key-schedule engine. Takes a master key and streams all T round
// keys, either in forward order or reversed. Reverse order is produced by
// running the forward schedule to the end of the key space (PRECOMP) and
// then walking it back with the inverse step, so no key storage is needed.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for a master key, key_ready high
//   PRECOMP | decrypt only: forward steps until window holds k[T-M..T-1]
//   EMIT    | presenting one round key per accepted beat
module simon_key_sched
  import simon_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_valid,
  output logic           key_ready,
  input  logic [M*N-1:0] key_in,
  input  logic           key_dec,
  output logic           rk_valid,
  input  logic           rk_ready,
  output logic [N-1:0]   rk_out,
  output logic [6:0]     rk_index,
  output logic           rk_last
);

  localparam int T = simon_rounds(N, M);
  localparam int J = simon_zsel(N, M);

  if (!simon_legal(N, M)) begin : g_illegal_cfg
    $error("simon_key_sched: illegal (N,M) = (%0d,%0d)", N, M);
  end

  localparam logic [61:0] Z_SEQ    = Z_TABLE[J];
  localparam logic [6:0]  T_LAST   = 7'(T - 1);
  localparam logic [6:0]  PRE_LAST = 7'(T - M - 1);

  state_e              state_q;
  logic [M-1:0][N-1:0] w_q;
  logic [6:0]          r_q;
  logic [5:0]          zi_q;
  logic                dec_q;
  logic                rk_valid_q;
  logic [N-1:0]        rk_out_q;
  logic [6:0]          rk_index_q;
  logic                rk_last_q;

  logic                accept;
  logic                key_ready_d;
  logic                load;
  logic                step_inv;
  logic                step_z;
  logic [N-1:0]        step_word;
  logic [5:0]          zi_inc_d;
  logic [5:0]          zi_dec_d;
  logic [M-1:0][N-1:0] w_fwd_d;
  logic [M-1:0][N-1:0] w_inv_d;

  // Handshake decode, z index neighbours and the two shifted windows.
  always_comb begin
    accept      = rk_valid_q & rk_ready;
    key_ready_d = (state_q == IDLE) | (accept & rk_last_q);
    load        = key_valid & key_ready_d;
    step_inv    = (state_q == EMIT) & dec_q;
    zi_inc_d    = (zi_q == 6'd61) ? 6'd0  : zi_q + 6'd1;
    zi_dec_d    = (zi_q == 6'd0)  ? 6'd61 : zi_q - 6'd1;
    // The inverse step regenerates k[i-1], which used z[i-1] going forward.
    step_z      = step_inv ? Z_SEQ[zi_dec_d] : Z_SEQ[zi_q];
    w_fwd_d     = {step_word, w_q[M-1:1]};
    w_inv_d     = {w_q[M-2:0], step_word};
  end

  simon_key_step #(
    .N (N),
    .M (M)
  ) u_step (
    .win_i  (w_q),
    .z_i    (step_z),
    .inv_i  (step_inv),
    .word_o (step_word)
  );

  // Controller: key load, precompute walk and registered round-key beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      w_q        <= '0;
      r_q        <= '0;
      zi_q       <= '0;
      dec_q      <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_out_q   <= '0;
      rk_index_q <= '0;
      rk_last_q  <= 1'b0;
    end else if (load) begin
      // Covers both a key in IDLE and a key taken on the final beat.
      w_q        <= key_in;
      r_q        <= '0;
      zi_q       <= '0;
      dec_q      <= key_dec;
      rk_index_q <= '0;
      rk_last_q  <= 1'b0;
      if (key_dec) begin
        state_q    <= PRECOMP;
        rk_valid_q <= 1'b0;
      end else begin
        state_q    <= EMIT;
        rk_valid_q <= 1'b1;
        rk_out_q   <= key_in[N-1:0];
      end
    end else begin
      case (state_q)
        IDLE: begin
        end
        PRECOMP: begin
          w_q  <= w_fwd_d;
          zi_q <= zi_inc_d;
          if (r_q == PRE_LAST) begin
            // The word generated now is k[T-1], the first decrypt beat.
            state_q    <= EMIT;
            r_q        <= '0;
            rk_valid_q <= 1'b1;
            rk_out_q   <= step_word;
            rk_index_q <= T_LAST;
            rk_last_q  <= 1'b0;
          end else begin
            r_q <= r_q + 7'd1;
          end
        end
        EMIT: begin
          if (accept) begin
            if (rk_last_q) begin
              state_q    <= IDLE;
              rk_valid_q <= 1'b0;
            end else begin
              r_q       <= r_q + 7'd1;
              rk_last_q <= ((r_q + 7'd1) == T_LAST);
              if (dec_q) begin
                w_q        <= w_inv_d;
                zi_q       <= zi_dec_d;
                rk_out_q   <= w_q[M-2];
                rk_index_q <= rk_index_q - 7'd1;
              end else begin
                w_q        <= w_fwd_d;
                zi_q       <= zi_inc_d;
                rk_out_q   <= w_q[1];
                rk_index_q <= rk_index_q + 7'd1;
              end
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          rk_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign key_ready = key_ready_d;
  assign rk_valid  = rk_valid_q;
  assign rk_out    = rk_out_q;
  assign rk_index  = rk_index_q;
  assign rk_last   = rk_last_q;

endmodule

// File: tb/tb_simon_key_sched.sv
// Bench for simon_key_sched: directed and random streams on N=16/M=4 plus
// a random encrypt/decrypt sweep over every legal (N,M) pair, all checked
// against an array-based expansion of the key schedule.
module tb_simon_key_sched;

  localparam int N = 16;
  localparam int M = 4;
  localparam int T = 32;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key_in;
  logic        key_dec;
  logic        rk_valid;
  logic        rk_ready;
  logic [15:0] rk_out;
  logic [6:0]  rk_index;
  logic        rk_last;

  logic        sw_rst;
  int          sweep_done = 0;

  int          n_checks = 0;
  int          n_errors = 0;

  logic [15:0] cap_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit z_elem(input int j, input int t);
    string s;
    case (j)
      0:       s = "11111010001001010110000111001101111101000100101011000011100110";
      1:       s = "10001110111110010011000010110101000111011111001001100001011010";
      2:       s = "10101111011100000011010010011000101000010001111110010110110011";
      3:       s = "11011011101011000110010111100000010010001010011100110100001111";
      default: s = "11010001111001101011011000100000010111000011001010010011101111";
    endcase
    return s[t] == "1";
  endfunction

  function automatic int pair_n(input int g);
    int tbl[10] = '{16, 24, 24, 32, 32, 48, 48, 64, 64, 64};
    return tbl[g];
  endfunction

  function automatic int pair_m(input int g);
    int tbl[10] = '{4, 3, 4, 3, 4, 2, 3, 2, 3, 4};
    return tbl[g];
  endfunction

  function automatic int ref_rounds(input int n, input int m);
    for (int g = 0; g < 10; g++) begin
      int tbl[10] = '{32, 36, 36, 42, 44, 52, 54, 68, 69, 72};
      if (pair_n(g) == n && pair_m(g) == m) return tbl[g];
    end
    return 0;
  endfunction

  function automatic int ref_zsel(input int n, input int m);
    for (int g = 0; g < 10; g++) begin
      int tbl[10] = '{0, 0, 1, 2, 3, 2, 3, 2, 3, 4};
      if (pair_n(g) == n && pair_m(g) == m) return tbl[g];
    end
    return 0;
  endfunction

  function automatic longint unsigned ror_n(input longint unsigned x, input int s, input int n,
                                            input longint unsigned mask);
    return ((x >> s) | (x << (n - s))) & mask;
  endfunction

  // Expands the whole schedule up to idx and returns k[idx].
  function automatic longint unsigned ref_key(input int n, input int m, input logic [255:0] key,
                                              input int idx);
    longint unsigned k[80];
    longint unsigned mask;
    longint unsigned tmp;
    longint unsigned zb;
    int j;
    j    = ref_zsel(n, m);
    mask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    for (int w = 0; w < m; w++) k[w] = 64'(key >> (w * n)) & mask;
    for (int i = m; i <= idx; i++) begin
      tmp = ror_n(k[i-1], 3, n, mask);
      if (m == 4) tmp = tmp ^ k[i-3];
      tmp = tmp ^ ror_n(tmp, 1, n, mask);
      zb  = {63'd0, z_elem(j, (i - m) % 62)};
      k[i] = (mask ^ 64'd3) ^ zb ^ k[i-m] ^ tmp;
    end
    return k[idx];
  endfunction

  // ---------------- main DUT (N=16, M=4) ----------------
  simon_key_sched #(.N(N), .M(M)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .key_dec   (key_dec),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_out    (rk_out),
    .rk_index  (rk_index),
    .rk_last   (rk_last)
  );

  // Offer a key at a falling edge, return at the falling edge after the handshake.
  task automatic drive_key(input logic [255:0] key, input bit dec);
    int cyc;
    key_in    = key[63:0];
    key_dec   = dec;
    key_valid = 1'b1;
    #1;
    cyc = 0;
    while (!key_ready && cyc < 500) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_val("key_ready_wait", 64'(key_ready), 64'd1);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic check_latency(input string tag, input int exp);
    int lat;
    lat = 1;
    #1;
    while (!rk_valid && lat < 200) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check_val(tag, 64'(lat), 64'(exp));
  endtask

  // Accept nbeats beats with rk_ready asserted pct% of cycles; every beat and
  // every stalled cycle is compared against the model.
  task automatic collect(input logic [255:0] key, input bit dec, input int pct, input int nbeats);
    int          got;
    int          cyc;
    int          e_idx;
    bit          stalled;
    logic [15:0] h_out;
    logic [6:0]  h_idx;
    logic        h_last;
    got     = 0;
    cyc     = 0;
    stalled = 1'b0;
    h_out   = '0;
    h_idx   = '0;
    h_last  = 1'b0;
    cap_q.delete();
    while (got < nbeats && cyc < 2000) begin
      rk_ready = (int'($urandom_range(99)) < pct);
      #1;
      if (stalled) begin
        check_val("stall_valid", 64'(rk_valid), 64'd1);
        check_val("stall_out", 64'(rk_out), 64'(h_out));
        check_val("stall_index", 64'(rk_index), 64'(h_idx));
        check_val("stall_last", 64'(rk_last), 64'(h_last));
      end
      stalled = 1'b0;
      if (rk_valid) begin
        check_val("key_ready_emit", 64'(key_ready), 64'(rk_ready && (got == T - 1)));
        if (rk_ready) begin
          e_idx = dec ? (T - 1 - got) : got;
          check_val("rk_index", 64'(rk_index), 64'(e_idx));
          check_val("rk_out", 64'(rk_out), ref_key(N, M, key, e_idx));
          check_val("rk_last", 64'(rk_last), 64'(got == T - 1));
          cap_q.push_back(rk_out);
          got++;
        end else begin
          stalled = 1'b1;
          h_out   = rk_out;
          h_idx   = rk_index;
          h_last  = rk_last;
        end
      end
      @(negedge clk);
      cyc++;
    end
    check_val("collect_beats", 64'(got), 64'(nbeats));
  endtask

  // ---------------- sweep over all legal (N,M) ----------------
  for (genvar g = 0; g < 10; g++) begin : g_sweep
    localparam int SN = pair_n(g);
    localparam int SM = pair_m(g);
    localparam int ST = ref_rounds(SN, SM);

    logic              kv;
    logic              kr;
    logic              kd;
    logic [SN*SM-1:0]  ki;
    logic              rv;
    logic              rr;
    logic [SN-1:0]     ro;
    logic [6:0]        ri;
    logic              rl;

    simon_key_sched #(.N(SN), .M(SM)) u_dut (
      .clk       (clk),
      .rst       (sw_rst),
      .key_valid (kv),
      .key_ready (kr),
      .key_in    (ki),
      .key_dec   (kd),
      .rk_valid  (rv),
      .rk_ready  (rr),
      .rk_out    (ro),
      .rk_index  (ri),
      .rk_last   (rl)
    );

    initial begin
      logic [255:0] key;
      int           got;
      int           cyc;
      int           e_idx;
      bit           stalled;
      logic [SN-1:0] h_out;
      logic [6:0]   h_idx;
      kv = 1'b0;
      kd = 1'b0;
      rr = 1'b0;
      ki = '0;
      repeat (6) @(negedge clk);
      for (int mode = 0; mode < 2; mode++) begin
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        key = key & ((256'd1 << (SN * SM)) - 256'd1);
        ki  = key[SN*SM-1:0];
        kd  = mode[0];
        kv  = 1'b1;
        #1;
        cyc = 0;
        while (!kr && cyc < 100) begin
          @(negedge clk);
          #1;
          cyc++;
        end
        check_val($sformatf("sw%0d_key_ready", g), 64'(kr), 64'd1);
        @(negedge clk);
        kv      = 1'b0;
        got     = 0;
        cyc     = 0;
        stalled = 1'b0;
        h_out   = '0;
        h_idx   = '0;
        while (got < ST && cyc < 1000) begin
          rr = 1'($urandom_range(1));
          #1;
          if (stalled) begin
            check_val($sformatf("sw%0d_stall_out", g), 64'(ro), 64'(h_out));
            check_val($sformatf("sw%0d_stall_index", g), 64'(ri), 64'(h_idx));
          end
          stalled = 1'b0;
          if (rv) begin
            if (rr) begin
              e_idx = (mode == 1) ? (ST - 1 - got) : got;
              check_val($sformatf("sw%0d_index", g), 64'(ri), 64'(e_idx));
              check_val($sformatf("sw%0d_out_m%0d_i%0d", g, mode, e_idx), 64'(ro),
                        ref_key(SN, SM, key, e_idx));
              check_val($sformatf("sw%0d_last", g), 64'(rl), 64'(got == ST - 1));
              got++;
            end else begin
              stalled = 1'b1;
              h_out   = ro;
              h_idx   = ri;
            end
          end
          @(negedge clk);
          cyc++;
        end
        check_val($sformatf("sw%0d_beats_m%0d", g, mode), 64'(got), 64'(ST));
      end
      sweep_done++;
    end
  end

  initial begin
    sw_rst = 1'b1;
    repeat (3) @(negedge clk);
    sw_rst = 1'b0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence on the main DUT ----------------
  initial begin
    logic [255:0] key_a;
    logic [255:0] key_b;
    logic [255:0] key_r;
    int           cyc;

    rst       = 1'b1;
    key_valid = 1'b0;
    key_in    = '0;
    key_dec   = 1'b0;
    rk_ready  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_rk_valid", 64'(rk_valid), 64'd0);
    check_val("rst_key_ready", 64'(key_ready), 64'd1);
    check_val("rst_rk_out", 64'(rk_out), 64'd0);
    check_val("rst_rk_index", 64'(rk_index), 64'd0);
    check_val("rst_rk_last", 64'(rk_last), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Published SIMON32/64 key: forward order and known first words.
    key_a = 256'h1918_1110_0908_0100;
    drive_key(key_a, 1'b0);
    check_latency("enc_latency", 1);
    collect(key_a, 1'b0, 100, T);
    check_val("vec_rk0", 64'(cap_q[0]), 64'h0100);
    check_val("vec_rk1", 64'(cap_q[1]), 64'h0908);
    check_val("vec_rk2", 64'(cap_q[2]), 64'h1110);
    check_val("vec_rk3", 64'(cap_q[3]), 64'h1918);
    check_val("vec_rk4", 64'(cap_q[4]), 64'h71C3);
    #1;
    check_val("enc_done_valid", 64'(rk_valid), 64'd0);
    check_val("enc_done_ready", 64'(key_ready), 64'd1);

    // Same key reversed.
    drive_key(key_a, 1'b1);
    check_latency("dec_latency", T - M + 1);
    collect(key_a, 1'b1, 100, T);
    check_val("dec_final_word", 64'(cap_q[T-1]), 64'h0100);
    #1;
    check_val("dec_done_valid", 64'(rk_valid), 64'd0);

    // Random key, both orders, consumer stalling about half the time.
    key_r = 256'({$urandom, $urandom});
    drive_key(key_r, 1'b0);
    check_latency("rnd_enc_latency", 1);
    collect(key_r, 1'b0, 50, T);
    drive_key(key_r, 1'b1);
    check_latency("rnd_dec_latency", T - M + 1);
    collect(key_r, 1'b1, 50, T);

    // Abort mid-stream after beat 5, then nothing more until a new key.
    rk_ready = 1'b1;
    key_r = 256'({$urandom, $urandom});
    drive_key(key_r, 1'b0);
    check_latency("abort_latency", 1);
    collect(key_r, 1'b0, 100, 6);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_val("abort_rk_valid", 64'(rk_valid), 64'd0);
    check_val("abort_key_ready", 64'(key_ready), 64'd1);
    check_val("abort_rk_index", 64'(rk_index), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check_val("abort_quiet", 64'(rk_valid), 64'd0);
    end
    key_r = 256'({$urandom, $urandom});
    drive_key(key_r, 1'b1);
    check_latency("post_abort_latency", T - M + 1);
    collect(key_r, 1'b1, 100, T);

    // Back-to-back: key B waits on the bus and loads on A's last beat.
    key_a = 256'({$urandom, $urandom});
    key_b = 256'({$urandom, $urandom});
    drive_key(key_a, 1'b0);
    check_latency("b2b_a_latency", 1);
    key_in    = key_b[63:0];
    key_dec   = 1'b0;
    key_valid = 1'b1;
    collect(key_a, 1'b0, 100, T);
    key_valid = 1'b0;
    #1;
    check_val("b2b_b_valid", 64'(rk_valid), 64'd1);
    check_val("b2b_b_index", 64'(rk_index), 64'd0);
    check_val("b2b_b_word0", 64'(rk_out), ref_key(N, M, key_b, 0));
    collect(key_b, 1'b0, 60, T);
    #1;
    check_val("b2b_done_valid", 64'(rk_valid), 64'd0);

    cyc = 0;
    while (sweep_done < 10 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check_val("sweep_done", 64'(sweep_done), 64'd10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
